vgasync_gen2: RTL and testbench

Parametrised second-generation VGA timing generator for the vdp99 display path. It produces hsync/vsync, active-video and border qualifiers, and active-pixel column/row coordinates. It also handles run-time graphics/text width switching applied only on frame boundaries, programmable sync polarity, an output alignment pipeline, and a vertical-blank interrupt flag with acknowledge handshake. It sits between the pixel clock and the VDP pixel fetch/serialiser.

---
 rtl/vgasync_gen2.sv | 179 +++++++++++++++++
 tb/tb_vgasync_gen2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vgasync_gen2.sv
// -----------------------------------------------------------------------------
// vgasync_gen2 -- parametrised VGA timing generator for the vdp99 display path.
//
// A free-running pixel/line counter pair is decoded into sync, active-video and
// border qualifiers plus active-pixel coordinates. All decoded outputs are
// registered together and then delayed by PIPE extra stages so they stay
// mutually aligned. A graphics/text width select is latched only at the frame
// wrap, and a sticky vertical-blank flag is raised at the start of the first
// non-active line.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-low reset
//   text_mode    in   1 = text width; latched only on the last pixel of a frame
//   irq_ack      in   clears vblank_irq (a set on the same edge wins)
//   hsync/vsync  out  sync outputs, asserted level HSPOL/VSPOL
//   vid_active   out  pixel is inside the active area
//   border       out  pixel is in a visible border
//   col/row      out  active pixel coordinates, 0 outside the active area
//   line_start   out  one-cycle pulse for h==0
//   frame_start  out  one-cycle pulse for h==0, v==0
//   vblank_irq   out  sticky vertical-blank flag
//   dbg_mode_q   out  latched width mode (debug visibility of mode_q)
//
// vblank_irq handshake: the flag rises on the edge that sees position
// (0,VVID) and stays high until an edge samples irq_ack==1 without a
// simultaneous set; a set on that same edge keeps it high.
// -----------------------------------------------------------------------------
module vgasync_gen2 #(
  parameter int HVID     = 512,
  parameter int HRB      = 64,
  parameter int HFP      = 16,
  parameter int HS       = 96,
  parameter int HBP      = 48,
  parameter int HLB      = 64,
  parameter int VVID     = 384,
  parameter int VBB      = 48,
  parameter int VFP      = 10,
  parameter int VS       = 2,
  parameter int VBP      = 33,
  parameter int VTB      = 48,
  parameter int TXT_TRIM = 16,
  parameter bit HSPOL    = 1'b0,
  parameter bit VSPOL    = 1'b0,
  parameter int PIPE     = 0,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          text_mode,
  input  logic          irq_ack,
  output logic          hsync,
  output logic          vsync,
  output logic          vid_active,
  output logic          border,
  output logic [HW-1:0] col,
  output logic [VW-1:0] row,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_irq,
  output logic          dbg_mode_q
);

  localparam int HTOT = HVID + HRB + HFP + HS + HBP + HLB;
  localparam int VTOT = VVID + VBB + VFP + VS + VBP + VTB;
  localparam int W    = 6 + HW + VW;

  localparam logic [HW-1:0] C_H_LAST   = HW'(HTOT - 1);
  localparam logic [VW-1:0] C_V_LAST   = VW'(VTOT - 1);
  localparam logic [HW-1:0] C_HVID     = HW'(HVID);
  localparam logic [VW-1:0] C_VVID     = VW'(VVID);
  localparam logic [HW-1:0] C_T_LO     = HW'(TXT_TRIM);
  localparam logic [HW-1:0] C_T_HI     = HW'(HVID - TXT_TRIM);
  localparam logic [HW-1:0] C_H_RB_END = HW'(HVID + HRB);
  localparam logic [HW-1:0] C_H_LB_BEG = HW'(HTOT - HLB);
  localparam logic [VW-1:0] C_V_BB_END = VW'(VVID + VBB);
  localparam logic [VW-1:0] C_V_TB_BEG = VW'(VTOT - VTB);
  localparam logic [HW-1:0] C_HS_BEG   = HW'(HVID + HRB + HFP);
  localparam logic [HW-1:0] C_HS_END   = HW'(HVID + HRB + HFP + HS);
  localparam logic [VW-1:0] C_VS_BEG   = VW'(VVID + VBB + VFP);
  localparam logic [VW-1:0] C_VS_END   = VW'(VVID + VBB + VFP + VS);

  // Reset image of the output bundle: syncs deasserted, everything else 0.
  localparam logic [W-1:0] C_RST = {~HSPOL, ~VSPOL, {(W-2){1'b0}}};

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_mode;
  logic          r_irq;
  logic [W-1:0]  r_pipe [0:PIPE];

  logic          w_act_g;
  logic          w_act_t;
  logic          w_act;
  logic          w_vis_h;
  logic          w_vis_v;
  logic          w_hs;
  logic          w_vs;
  logic [HW-1:0] w_col;
  logic [VW-1:0] w_row;
  logic [W-1:0]  w_dec;

  // Position counters and frame-boundary mode latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h    <= '0;
      r_v    <= '0;
      r_mode <= 1'b0;
    end else if (r_h == C_H_LAST) begin
      r_h <= '0;
      if (r_v == C_V_LAST) begin
        r_v    <= '0;
        // Loaded on the last pixel so the new width applies from (0,0).
        r_mode <= text_mode;
      end else begin
        r_v <= r_v + VW'(1);
      end
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Position decode.
  always_comb begin
    w_act_g = (r_h < C_HVID);
    w_act_t = (r_h >= C_T_LO) && (r_h < C_T_HI);
    w_act   = (r_mode ? w_act_t : w_act_g) && (r_v < C_VVID);
    w_col   = '0;
    w_row   = '0;
    if (w_act) begin
      w_col = r_mode ? (r_h - C_T_LO) : r_h;
      w_row = r_v;
    end
    // Guards keep a zero-width left/top border from wrapping to "always".
    w_vis_h = (r_h < C_H_RB_END) || ((HLB != 0) && (r_h >= C_H_LB_BEG));
    w_vis_v = (r_v < C_V_BB_END) || ((VTB != 0) && (r_v >= C_V_TB_BEG));
    w_hs    = (r_h >= C_HS_BEG) && (r_h < C_HS_END);
    w_vs    = (r_v >= C_VS_BEG) && (r_v < C_VS_END);
    w_dec   = {(w_hs ? HSPOL : ~HSPOL),
               (w_vs ? VSPOL : ~VSPOL),
               w_act,
               (w_vis_h && w_vis_v && !w_act),
               w_col,
               w_row,
               (r_h == '0),
               (r_h == '0) && (r_v == '0)};
  end

  // Stage 0 registers the decode; stages 1..PIPE only add delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_pipe[i] <= C_RST;
      end
    end else begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i <= PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Vertical-blank flag sits outside the alignment pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else if ((r_h == '0) && (r_v == C_VVID)) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign {hsync, vsync, vid_active, border, col, row, line_start, frame_start} = r_pipe[PIPE];
  assign vblank_irq = r_irq;
  assign dbg_mode_q = r_mode;

endmodule

// File: tb/tb_vgasync_gen2.sv
// Bench for vgasync_gen2: two instances (PIPE=0 and PIPE=3) driven by the same
// stimulus, a frame-position model checked every cycle, and literal spot checks.
module tb_vgasync_gen2;

  localparam int HVID = 5, HRB = 2, HFP = 2, HS = 3, HBP = 4, HLB = 2;
  localparam int VVID = 3, VBB = 2, VFP = 4, VS = 2, VBP = 3, VTB = 2;
  localparam int TRIM = 1;
  localparam int HW = 10, VW = 10;
  localparam int W = 6 + HW + VW;
  localparam int HTOT = HVID + HRB + HFP + HS + HBP + HLB;
  localparam int VTOT = VVID + VBB + VFP + VS + VBP + VTB;
  localparam int FRAME = HTOT * VTOT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic text_mode = 1'b0;
  logic irq_ack = 1'b0;
  always #5 clk = ~clk;

  logic          hsync0, vsync0, vid0, border0, ls0, fs0, irq0, mode0;
  logic [HW-1:0] col0;
  logic [VW-1:0] row0;
  logic          hsync3, vsync3, vid3, border3, ls3, fs3, irq3, mode3;
  logic [HW-1:0] col3;
  logic [VW-1:0] row3;

  vgasync_gen2 #(
    .HVID(HVID), .HRB(HRB), .HFP(HFP), .HS(HS), .HBP(HBP), .HLB(HLB),
    .VVID(VVID), .VBB(VBB), .VFP(VFP), .VS(VS), .VBP(VBP), .VTB(VTB),
    .TXT_TRIM(TRIM), .HSPOL(1'b0), .VSPOL(1'b0), .PIPE(0), .HW(HW), .VW(VW)
  ) dut0 (
    .clk(clk), .reset(reset), .text_mode(text_mode), .irq_ack(irq_ack),
    .hsync(hsync0), .vsync(vsync0), .vid_active(vid0), .border(border0),
    .col(col0), .row(row0), .line_start(ls0), .frame_start(fs0),
    .vblank_irq(irq0), .dbg_mode_q(mode0)
  );

  vgasync_gen2 #(
    .HVID(HVID), .HRB(HRB), .HFP(HFP), .HS(HS), .HBP(HBP), .HLB(HLB),
    .VVID(VVID), .VBB(VBB), .VFP(VFP), .VS(VS), .VBP(VBP), .VTB(VTB),
    .TXT_TRIM(TRIM), .HSPOL(1'b0), .VSPOL(1'b0), .PIPE(3), .HW(HW), .VW(VW)
  ) dut3 (
    .clk(clk), .reset(reset), .text_mode(text_mode), .irq_ack(irq_ack),
    .hsync(hsync3), .vsync(vsync3), .vid_active(vid3), .border(border3),
    .col(col3), .row(row3), .line_start(ls3), .frame_start(fs3),
    .vblank_irq(irq3), .dbg_mode_q(mode3)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit started = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected output bundle for pixel (h,v) in width mode m, from the region rules.
  function automatic logic [W-1:0] model_out(input int h, input int v, input bit m);
    bit act, vis, hs, vs;
    int c, r;
    logic [HW-1:0] cw;
    logic [VW-1:0] rw;
    if (m) act = (h >= TRIM) && (h < HVID - TRIM) && (v < VVID);
    else   act = (h < HVID) && (v < VVID);
    c   = act ? (m ? h - TRIM : h) : 0;
    r   = act ? v : 0;
    cw  = HW'(c);
    rw  = VW'(r);
    vis = ((h < HVID + HRB) || (h >= HTOT - HLB)) && ((v < VVID + VBB) || (v >= VTOT - VTB));
    hs  = (h >= HVID + HRB + HFP) && (h < HVID + HRB + HFP + HS);
    vs  = (v >= VVID + VBB + VFP) && (v < VVID + VBB + VFP + VS);
    return {~hs, ~vs, act, vis & ~act, cw, rw, (h == 0), (h == 0) && (v == 0)};
  endfunction

  // Model: a linear pixel index within the frame, advanced on every edge.
  initial begin : model_proc
    int p;
    bit m_mode;
    bit m_irq;
    logic [W-1:0] rst_img;
    p = 0;
    m_mode = 1'b0;
    m_irq = 1'b0;
    rst_img = {2'b11, {(W-2){1'b0}}};
    forever begin
      @(posedge clk);
      if (!reset) begin
        p = 0;
        m_mode = 1'b0;
        m_irq = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(rst_img);
        cyc = 0;
        started = 1'b1;
      end else begin
        exp_q.push_front(model_out(p % HTOT, p / HTOT, m_mode));
        void'(exp_q.pop_back());
        if (p == VVID * HTOT) m_irq = 1'b1;
        else if (irq_ack) m_irq = 1'b0;
        if (p == FRAME - 1) m_mode = text_mode;
        p = (p + 1) % FRAME;
        cyc++;
      end
      #1;
      if (started) begin
        chk("pipe0_bundle", {hsync0, vsync0, vid0, border0, col0, row0, ls0, fs0}, 32'(exp_q[0]));
        chk("pipe3_bundle", {hsync3, vsync3, vid3, border3, col3, row3, ls3, fs3}, 32'(exp_q[3]));
        chk("irq0", irq0, 32'(m_irq));
        chk("irq3", irq3, 32'(m_irq));
        chk("mode_q", mode0, 32'(m_mode));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_cycle(input int c);
    int guard;
    guard = 0;
    while (cyc != c && guard < 2000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (cyc != c) chk("cycle_wait_timeout", 32'(cyc), 32'(c));
  endtask

  initial begin : driver
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;

    // First line after reset
    to_cycle(1);
    chk("c1_vid", vid0, 1); chk("c1_col", col0, 0);
    chk("c1_line_start", ls0, 1); chk("c1_frame_start", fs0, 1);
    to_cycle(3);  chk("c3_pipe3_vid", vid3, 0); chk("c3_pipe3_hsync", hsync3, 1);
    to_cycle(4);  chk("c4_pipe3_vid", vid3, 1); chk("c4_pipe3_col", col3, 0);
    to_cycle(5);  chk("c5_col", col0, 4);
    to_cycle(6);  chk("c6_vid", vid0, 0); chk("c6_border", border0, 1);
    to_cycle(8);  chk("c8_border", border0, 0);
    to_cycle(10); chk("c10_hsync", hsync0, 0);
    to_cycle(13); chk("c13_hsync", hsync0, 1);
    to_cycle(17); chk("c17_border", border0, 1);
    to_cycle(19); chk("c19_line_start", ls0, 1); chk("c19_row", row0, 1);

    // Mid-frame text_mode request: ignored until the frame wraps
    to_cycle(20); text_mode = 1'b1;
    to_cycle(37); chk("c37_vid_graphics", vid0, 1); chk("c37_col", col0, 0);

    // IRQ set and single-cycle ack
    to_cycle(54);  chk("c54_irq", irq0, 0);
    to_cycle(55);  chk("c55_irq", irq0, 1);
    to_cycle(100); chk("c100_irq_hold", irq0, 1); irq_ack = 1'b1;
    to_cycle(101); chk("c101_irq_clear", irq0, 0); irq_ack = 1'b0;

    // Vertical sync window
    to_cycle(162); chk("c162_vsync", vsync0, 1);
    to_cycle(163); chk("c163_vsync", vsync0, 0);
    to_cycle(198); chk("c198_vsync", vsync0, 0);
    to_cycle(199); chk("c199_vsync", vsync0, 1);

    // Frame wrap: mode latch and text-width line
    to_cycle(287); chk("c287_mode", mode0, 0);
    to_cycle(288); chk("c288_mode", mode0, 1); chk("c288_frame_start", fs0, 0);
    to_cycle(289); chk("c289_frame_start", fs0, 1); chk("c289_vid", vid0, 0);
    chk("c289_border", border0, 1);
    to_cycle(290); chk("c290_vid", vid0, 1); chk("c290_col", col0, 0);
    to_cycle(292); chk("c292_col", col0, 2);
    to_cycle(293); chk("c293_vid", vid0, 0); chk("c293_border", border0, 1);

    // Ack held on the set edge: set wins
    to_cycle(341); irq_ack = 1'b1;
    to_cycle(343); chk("c343_irq_set_wins", irq0, 1); irq_ack = 1'b0;
    to_cycle(350); chk("c350_irq_hold", irq0, 1);

    // Mid-frame reset at v=7 of the second frame
    to_cycle(414); reset = 1'b0;
    to_cycle(0);
    chk("rst_hsync", hsync0, 1); chk("rst_vsync", vsync0, 1);
    chk("rst_vid", vid0, 0); chk("rst_irq", irq0, 0);
    chk("rst_mode", mode0, 0); chk("rst_pipe3_hsync", hsync3, 1);
    reset = 1'b1;
    to_cycle(1); chk("r1_frame_start", fs0, 1); chk("r1_vid", vid0, 1); chk("r1_col", col0, 0);
    to_cycle(2); chk("r2_col_graphics", col0, 1);

    to_cycle(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
